cory_arb8: RTL and testbench
============================

// Module: cory_arb8
// PURPOSE
//  Round-robin packet scheduler for an 8-input valid/ready select-mux (cory_mux8-style).
//  Observes the 8 lane valids and lane last-flags; drives the mux select token (o_s_v/o_s_d/i_s_r).
//  Holds one lane per packet or burst, then rotates priority, so 8 requesters share a single downstream queue fairly.
// PARAMETERS
//  B   0   max beats per grant; 0 = unlimited (grant ends only on last)
//  T   4   starvation timeout: cycles a granted lane with 0 beats may sit idle before release; 0 = off
// PORTS
//  clk       in   1  clock
//  reset_n   in   1  asynchronous active-low reset
//  i_req_v   in   8  lane valids, bit k = i_ak_v (tap, not consumed)
//  i_req_l   in   8  lane last flags, bit k = end of packet on lane k (meaningful only with bit k of i_req_v)
//  o_s_v     out  1  select token valid, to mux i_s_v
//  o_s_d     out  3  selected lane, to mux i_s_d
//  i_s_r     in   1  select ready, from mux o_s_r
//  o_gnt     out  8  one-hot of current grant; 0 when idle
//  o_busy    out  1  1 while in GRANT
// BEHAVIOUR
//  Reset: o_s_v=0, o_s_d=0, o_gnt=0, o_busy=0, ptr=0, beats=0, idle_cnt=0, state=IDLE. Async clear.
//    o_s_v drops in the same cycle as reset assertion; a beat in flight is discarded (not counted).
//  All outputs are registered or decoded only from state, cur and ptr; no comb path from i_req_* to o_s_*.
//  Winner selection: first set bit of i_req_v scanning ptr, ptr+1, ... ptr+7, modulo 8.
//  States:
//   IDLE: o_s_v=0. If |i_req_v: cur<=winner, beats<=0, idle_cnt<=0 -> GRANT.
//     Latency is 1 clk from request to o_s_v=1.
//   GRANT: o_s_v=1, o_s_d=cur, o_gnt=1<<cur.
//    fire = i_s_r & i_req_v[cur]. This is a beat actually transferred by the mux.
//      i_s_r with the lane invalid is not a beat.
//    On fire: beats<=beats+1 (saturate at 2^16-1). beats is a 16-bit counter; B must be <= 65535.
//    release = fire & (i_req_l[cur] | (B!=0 & beats==B-1)).
//    timeout = T!=0 & beats==0 & ~i_req_v[cur] & idle_cnt==T-1.
//      idle_cnt counts consecutive cycles with ~i_req_v[cur] and beats==0.
//      idle_cnt clears whenever i_req_v[cur] is high.
//      Once beats>0, the grant is locked until release; mid-packet stalls never time out.
//    On release or timeout: ptr<=cur+1 (3-bit wrap, 7->0).
//     Re-arbitrate in the same cycle with ptr'=cur+1 over current i_req_v.
//      If there is a winner: cur<=winner, beats<=0, idle_cnt<=0, stay GRANT. This gives back-to-back grants with no bubble.
//      Otherwise -> IDLE.
//     The just-released lane may win again only if no other lane requests (lowest priority).
//  Simultaneous last and B limit: a single release; ptr advances once.
//  B=1: every beat rotates (beat-level round robin).
//  i_req_l on a non-granted lane is ignored.
//  The select token is never withdrawn while o_s_v=1 except by release/timeout, which change o_s_d only after a handshake or a zero-beat idle grant.
// STRUCTURE
//  Shared package cory_arb_pkg: SEL_W=3, NLANE=8, state encoding ST_IDLE=0/ST_GRANT=1, BEAT_W=16.
//  Sub-module cory_rr_pick8 (combinational): in req[7:0], ptr[2:0]; out found, win[2:0].
//    It is instantiated once and shared by the IDLE and re-arbitration paths.
//  Top: state reg, cur, ptr, beats, idle_cnt; output decode.
// TESTING
//  1 Reset then i_req_v=8'h01 with i_req_l[0]=1 and i_s_r=1.
//    -> o_s_v=1, o_s_d=0 one clk later. Release after 1 beat; ptr=1; IDLE.
//  2 i_req_v=8'hFF held, all last=1, i_s_r=1, ptr=0.
//    -> o_s_d sequence 0,1,2,...,7,0 with one beat each and no idle cycles.
//  3 Lane 3 sends a 4-beat packet (last on beat 4); lane 5 requests throughout; B=0.
//    -> o_s_d=3 for 4 fires, then 5. Lane 5 is never granted mid-packet.
//  4 B=2, lane 2 sends an 5-beat packet, lane 6 idle.
//    -> lane 2 regranted after every 2 beats (ptr 3), since it is the only requester.
//    Add lane 6 -> o_s_d alternates 2,2,6,...
//  5 T=4: lane 1 valid for 1 cycle (gets grant) then drops with beats=0; lane 4 requesting.
//    -> grant moves to 4 exactly 4 clks after lane 1 valid drops.
//    Repeat with beats=1 -> no timeout; lane 1 is held.
//  6 i_s_r=0 for 10 cycles mid-packet, then reset_n pulsed low.
//    -> o_s_d stable during stall. o_s_v, o_gnt, o_busy go 0 asynchronously. First grant after reset starts from ptr=0.

Source files
------------

// File: rtl/cory_arb_pkg.sv
// Shared definitions for the cory round-robin packet scheduler.
package cory_arb_pkg;

  localparam int SEL_W  = 3;
  localparam int NLANE  = 8;
  localparam int BEAT_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Next lane in rotation order; 3-bit wrap gives 7 -> 0.
  function automatic logic [SEL_W-1:0] lane_inc(input logic [SEL_W-1:0] lane);
    return lane + 1'b1;
  endfunction

endpackage

// File: rtl/cory_rr_pick8.sv
// Combinational round-robin picker: first set bit of req scanning ptr, ptr+1, ... ptr+7.
module cory_rr_pick8
  import cory_arb_pkg::*;
(
  input  logic [NLANE-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = NLANE - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/cory_arb8.sv
// Round-robin packet scheduler driving the select token of an 8-input valid/ready mux.
//   state    | meaning
//   ST_IDLE  | no grant, token invalid, waiting for any lane valid
//   ST_GRANT | lane cur holds the token until last, beat limit or zero-beat timeout
module cory_arb8
  import cory_arb_pkg::*;
#(
  parameter int B = 0,
  parameter int T = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NLANE-1:0] i_req_v,
  input  logic [NLANE-1:0] i_req_l,
  output logic             o_s_v,
  output logic [SEL_W-1:0] o_s_d,
  input  logic             i_s_r,
  output logic [NLANE-1:0] o_gnt,
  output logic             o_busy
);

  localparam logic [BEAT_W-1:0] B_LAST = BEAT_W'(B - 1);
  localparam logic [BEAT_W-1:0] T_LAST = BEAT_W'(T - 1);
  localparam bit B_ON = (B != 0);
  localparam bit T_ON = (T != 0);

  state_t            state, state_n;
  logic [SEL_W-1:0]  cur, cur_n;
  logic [SEL_W-1:0]  ptr, ptr_n;
  logic [BEAT_W-1:0] beats, beats_n;
  logic [BEAT_W-1:0] idle_cnt, idle_n;

  logic             granted;
  logic             cur_v;
  logic             cur_l;
  logic             fire;
  logic             rel;
  logic             tmo;
  logic [SEL_W-1:0] pick_ptr;
  logic             found;
  logic [SEL_W-1:0] win;

  assign granted  = (state == ST_GRANT);
  assign cur_v    = i_req_v[cur];
  assign cur_l    = i_req_l[cur];
  assign fire     = granted && i_s_r && cur_v;
  assign rel      = fire && (cur_l || (B_ON && (beats == B_LAST)));
  assign tmo      = granted && T_ON && (beats == '0) && !cur_v && (idle_cnt == T_LAST);

  // One picker serves both the idle path and same-cycle re-arbitration after release.
  assign pick_ptr = granted ? lane_inc(cur) : ptr;

  cory_rr_pick8 u_pick (
    .req   (i_req_v),
    .ptr   (pick_ptr),
    .found (found),
    .win   (win)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cur      <= '0;
      ptr      <= '0;
      beats    <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      ptr      <= ptr_n;
      beats    <= beats_n;
      idle_cnt <= idle_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    ptr_n   = ptr;
    beats_n = beats;
    idle_n  = idle_cnt;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_n = ST_GRANT;
          cur_n   = win;
          beats_n = '0;
          idle_n  = '0;
        end
      end
      ST_GRANT: begin
        if (rel || tmo) begin
          ptr_n   = lane_inc(cur);
          beats_n = '0;
          idle_n  = '0;
          if (found) begin
            cur_n = win;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          if (fire && (beats != '1)) begin
            beats_n = beats + 1'b1;
          end
          // Idle counting only matters before the first beat; afterwards the grant is locked.
          if (cur_v) begin
            idle_n = '0;
          end else if ((beats == '0) && (idle_cnt != '1)) begin
            idle_n = idle_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign o_busy = granted;
  assign o_s_v  = granted;
  assign o_s_d  = granted ? cur : '0;
  assign o_gnt  = granted ? (NLANE'(1) << cur) : '0;

endmodule

// File: tb/tb_cory_arb8.sv
// Randomized bench for cory_arb8: two parameterizations checked against a lane-level reference model.
module tb_cory_arb8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req_v;
  logic [7:0] req_l;
  logic       s_r;

  logic       sv   [2];
  logic [2:0] sd   [2];
  logic [7:0] gnt  [2];
  logic       busy [2];

  always #5 clk = ~clk;

  cory_arb8 #(.B(0), .T(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_req_v(req_v), .i_req_l(req_l),
    .o_s_v(sv[0]), .o_s_d(sd[0]), .i_s_r(s_r), .o_gnt(gnt[0]), .o_busy(busy[0])
  );

  cory_arb8 #(.B(2), .T(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_req_v(req_v), .i_req_l(req_l),
    .o_s_v(sv[1]), .o_s_d(sd[1]), .i_s_r(s_r), .o_gnt(gnt[1]), .o_busy(busy[1])
  );

  // Reference model state, one slot per instance
  int pb [2] = '{0, 2};
  int pt [2] = '{4, 0};
  bit m_busy  [2];
  int m_cur   [2];
  int m_ptr   [2];
  int m_beats [2];
  int m_idle  [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] req, input int start);
    for (int k = 0; k < 8; k++) begin
      if (req[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_cur[i] = 0; m_ptr[i] = 0; m_beats[i] = 0; m_idle[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int  w;
    bit  fire, rel, tmo;
    if (!m_busy[i]) begin
      w = pick(req_v, m_ptr[i]);
      if (w >= 0) begin
        m_busy[i] = 1; m_cur[i] = w; m_beats[i] = 0; m_idle[i] = 0;
      end
    end else begin
      fire = s_r && req_v[m_cur[i]];
      rel  = fire && (req_l[m_cur[i]] || (pb[i] != 0 && m_beats[i] + 1 == pb[i]));
      tmo  = pt[i] != 0 && m_beats[i] == 0 && !req_v[m_cur[i]] && m_idle[i] + 1 == pt[i];
      if (rel || tmo) begin
        m_ptr[i]   = (m_cur[i] + 1) % 8;
        m_beats[i] = 0;
        m_idle[i]  = 0;
        w = pick(req_v, m_ptr[i]);
        if (w >= 0) m_cur[i] = w;
        else        m_busy[i] = 0;
      end else begin
        if (req_v[m_cur[i]])     m_idle[i] = 0;
        else if (m_beats[i] == 0) m_idle[i]++;
        if (fire && m_beats[i] < 65535) m_beats[i]++;
      end
    end
  endtask

  task automatic check_outs(input string ph);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.s_v%0d", ph, i),  32'(sv[i]),   32'(m_busy[i]));
      chk($sformatf("%s.s_d%0d", ph, i),  32'(sd[i]),   m_busy[i] ? 32'(m_cur[i]) : 32'd0);
      chk($sformatf("%s.gnt%0d", ph, i),  32'(gnt[i]),  m_busy[i] ? (32'd1 << m_cur[i]) : 32'd0);
      chk($sformatf("%s.busy%0d", ph, i), 32'(busy[i]), 32'(m_busy[i]));
    end
  endtask

  // Check current outputs, drive the next inputs, advance the model across the coming edge.
  task automatic cyc(input string ph, input logic [7:0] v, input logic [7:0] l, input logic r);
    check_outs(ph);
    req_v = v;
    req_l = l;
    s_r   = r;
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic do_reset(input string ph);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_outs(ph);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req_v = '0;
    req_l = '0;
    s_r   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    reset_n = 1'b1;

    cyc("t1", 8'h01, 8'h01, 1'b1);
    cyc("t1", 8'h00, 8'h00, 1'b1);
    cyc("t1", 8'h01, 8'h01, 1'b1);
    cyc("t1", 8'h00, 8'h00, 1'b0);
    cyc("t1", 8'h03, 8'h00, 1'b0);
    cyc("t1", 8'h00, 8'h00, 1'b0);
    repeat (3) cyc("t1", 8'h00, 8'h00, 1'b0);

    repeat (20) cyc("t2", 8'hFF, 8'hFF, 1'b1);
    repeat (3) cyc("t2", 8'h00, 8'h00, 1'b0);

    for (int k = 0; k < 10; k++) cyc("t3", 8'h28, (k == 4) ? 8'h08 : 8'h00, 1'b1);
    repeat (3) cyc("t3", 8'h00, 8'h00, 1'b0);

    for (int k = 0; k < 12; k++) cyc("t4", (k < 6) ? 8'h04 : 8'h44, (k == 4) ? 8'h04 : 8'h00, 1'b1);
    repeat (3) cyc("t4", 8'h00, 8'h00, 1'b0);

    cyc("t5", 8'h02, 8'h00, 1'b1);
    repeat (7) cyc("t5", 8'h10, 8'h00, 1'b1);
    repeat (3) cyc("t5", 8'h00, 8'h00, 1'b0);
    cyc("t5", 8'h02, 8'h00, 1'b1);
    cyc("t5", 8'h02, 8'h00, 1'b1);
    repeat (7) cyc("t5", 8'h10, 8'h00, 1'b1);
    repeat (3) cyc("t5", 8'h12, 8'h02, 1'b1);

    repeat (1500) cyc("rnd", 8'($urandom), 8'($urandom & $urandom), ($urandom % 4) != 0);
    repeat (800) cyc("sparse", 8'($urandom & $urandom & $urandom), 8'($urandom), ($urandom % 3) != 0);

    repeat (3) cyc("t6", 8'h00, 8'h00, 1'b0);
    cyc("t6", 8'h28, 8'h00, 1'b1);
    repeat (2) cyc("t6", 8'h28, 8'h00, 1'b1);
    repeat (10) cyc("t6", 8'h28, 8'h00, 1'b0);
    cyc("t6", 8'h28, 8'h00, 1'b1);
    do_reset("areset");
    repeat (4) cyc("t6post", 8'h28, 8'h00, 1'b1);
    cyc("t6post", 8'h00, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
